// File: rtl/uart_echo_fifo.sv
// UART loopback: deserialises frames from uart_rx, queues the words in a FIFO
// and retransmits them on uart_tx with identical framing.
module uart_echo_fifo #(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        uart_rx,
    output logic                        uart_tx,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        rx_overrun,
    output logic                        parity_err,
    output logic                        frame_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BIT_HALF  = CW'(CLKS_PER_BIT / 2);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic [PW:0]   FIFO_FULL = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_e;

    logic sync1_q, sync2_q, rxPrev_q;

    state_e               rxState_q, rxState_d;
    logic [CW-1:0]        rxCnt_q, rxCnt_d;
    logic [3:0]           rxBit_q, rxBit_d;
    logic [DATA_BITS-1:0] rxShift_q, rxShift_d;
    logic                 rxPar_q, rxPar_d;
    logic                 rxBad_q, rxBad_d;
    logic                 rxDone, rxFrameBad, parityBad;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]        wrPtr_q, rdPtr_q;
    logic [PW:0]          count_q;
    logic                 fifoFull, fifoPush, txPop;

    state_e               txState_q, txState_d;
    logic [CW-1:0]        txCnt_q, txCnt_d;
    logic [3:0]           txBit_q, txBit_d;
    logic [DATA_BITS-1:0] txShift_q, txShift_d;
    logic                 txParBit_q, txParBit_d;
    logic                 tx_q, tx_d;
    logic                 txLastStop;

    // rxPrev_q holds the previous synchronised level so a held-low line cannot re-arm the receiver
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            rxPrev_q <= 1'b1;
        end else begin
            sync1_q  <= uart_rx;
            sync2_q  <= sync1_q;
            rxPrev_q <= sync2_q;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rxState_q <= ST_IDLE;
            rxCnt_q   <= '0;
            rxBit_q   <= '0;
            rxShift_q <= '0;
            rxPar_q   <= 1'b0;
            rxBad_q   <= 1'b0;
        end else begin
            rxState_q <= rxState_d;
            rxCnt_q   <= rxCnt_d;
            rxBit_q   <= rxBit_d;
            rxShift_q <= rxShift_d;
            rxPar_q   <= rxPar_d;
            rxBad_q   <= rxBad_d;
        end
    end

    always_comb begin
        rxState_d  = rxState_q;
        rxCnt_d    = rxCnt_q + 1'b1;
        rxBit_d    = rxBit_q;
        rxShift_d  = rxShift_q;
        rxPar_d    = rxPar_q;
        rxBad_d    = rxBad_q;
        rxDone     = 1'b0;
        rxFrameBad = 1'b0;
        case (rxState_q)
            ST_IDLE: begin
                rxCnt_d = '0;
                if (rxPrev_q && !sync2_q) rxState_d = ST_START;
            end
            ST_START: if (rxCnt_q == BIT_HALF) begin
                rxCnt_d   = '0;
                rxBit_d   = '0;
                rxPar_d   = 1'b0;
                rxBad_d   = 1'b0;
                rxState_d = sync2_q ? ST_IDLE : ST_DATA;
            end
            ST_DATA: if (rxCnt_q == BIT_LAST) begin
                rxCnt_d   = '0;
                rxShift_d = {sync2_q, rxShift_q[DATA_BITS-1:1]};
                rxPar_d   = rxPar_q ^ sync2_q;
                if (rxBit_q == DATA_LAST) begin
                    rxBit_d   = '0;
                    rxState_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
                end else begin
                    rxBit_d = rxBit_q + 1'b1;
                end
            end
            ST_PARITY: if (rxCnt_q == BIT_LAST) begin
                rxCnt_d   = '0;
                rxPar_d   = rxPar_q ^ sync2_q;
                rxState_d = ST_STOP;
            end
            ST_STOP: if (rxCnt_q == BIT_LAST) begin
                rxCnt_d = '0;
                rxBad_d = rxBad_q | !sync2_q;
                if (rxBit_q == STOP_LAST) begin
                    rxDone     = 1'b1;
                    rxFrameBad = rxBad_d;
                    rxState_d  = ST_IDLE;
                end else begin
                    rxBit_d = rxBit_q + 1'b1;
                end
            end
            default: rxState_d = ST_IDLE;
        endcase
    end

    // rxPar_q accumulates data bits plus the received parity bit
    assign parityBad  = (PARITY == 1) ? !rxPar_q : (PARITY == 2) ? rxPar_q : 1'b0;
    assign fifoFull   = (count_q == FIFO_FULL);
    assign frame_err  = rxDone && rxFrameBad;
    assign parity_err = rxDone && !rxFrameBad && parityBad;
    assign rx_overrun = rxDone && !rxFrameBad && !parityBad && fifoFull && !txPop;
    assign fifoPush   = rxDone && !rxFrameBad && !parityBad && (!fifoFull || txPop);
    assign fifo_count = count_q;

    always_ff @(posedge clock) begin
        if (fifoPush) mem_q[wrPtr_q] <= rxShift_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (fifoPush) wrPtr_q <= wrPtr_q + 1'b1;
            if (txPop)    rdPtr_q <= rdPtr_q + 1'b1;
            if (fifoPush && !txPop)      count_q <= count_q + 1'b1;
            else if (txPop && !fifoPush) count_q <= count_q - 1'b1;
        end
    end

    // Popping on the last stop cycle lets queued frames leave back-to-back
    assign txLastStop = (txState_q == ST_STOP) && (txCnt_q == BIT_LAST) && (txBit_q == STOP_LAST);
    assign txPop      = (count_q != '0) && ((txState_q == ST_IDLE) || txLastStop);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            txState_q  <= ST_IDLE;
            txCnt_q    <= '0;
            txBit_q    <= '0;
            txShift_q  <= '0;
            txParBit_q <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            txState_q  <= txState_d;
            txCnt_q    <= txCnt_d;
            txBit_q    <= txBit_d;
            txShift_q  <= txShift_d;
            txParBit_q <= txParBit_d;
            tx_q       <= tx_d;
        end
    end

    always_comb begin
        txState_d  = txState_q;
        txCnt_d    = txCnt_q + 1'b1;
        txBit_d    = txBit_q;
        txShift_d  = txShift_q;
        txParBit_d = txParBit_q;
        tx_d       = tx_q;
        if (txPop) begin
            txState_d  = ST_START;
            txCnt_d    = '0;
            txShift_d  = mem_q[rdPtr_q];
            txParBit_d = (PARITY == 1) ? ~^mem_q[rdPtr_q] : ^mem_q[rdPtr_q];
            tx_d       = 1'b0;
        end else begin
            case (txState_q)
                ST_IDLE: begin
                    txCnt_d = '0;
                    tx_d    = 1'b1;
                end
                ST_START: if (txCnt_q == BIT_LAST) begin
                    txCnt_d   = '0;
                    txBit_d   = '0;
                    tx_d      = txShift_q[0];
                    txShift_d = txShift_q >> 1;
                    txState_d = ST_DATA;
                end
                ST_DATA: if (txCnt_q == BIT_LAST) begin
                    txCnt_d = '0;
                    if (txBit_q == DATA_LAST) begin
                        txBit_d = '0;
                        if (PARITY != 0) begin
                            txState_d = ST_PARITY;
                            tx_d      = txParBit_q;
                        end else begin
                            txState_d = ST_STOP;
                            tx_d      = 1'b1;
                        end
                    end else begin
                        txBit_d   = txBit_q + 1'b1;
                        tx_d      = txShift_q[0];
                        txShift_d = txShift_q >> 1;
                    end
                end
                ST_PARITY: if (txCnt_q == BIT_LAST) begin
                    txCnt_d   = '0;
                    txBit_d   = '0;
                    txState_d = ST_STOP;
                    tx_d      = 1'b1;
                end
                ST_STOP: if (txCnt_q == BIT_LAST) begin
                    txCnt_d = '0;
                    tx_d    = 1'b1;
                    if (txBit_q == STOP_LAST) txState_d = ST_IDLE;
                    else                      txBit_d   = txBit_q + 1'b1;
                end
                default: begin
                    txState_d = ST_IDLE;
                    tx_d      = 1'b1;
                end
            endcase
        end
    end

    assign uart_tx = tx_q;

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Bench for uart_echo_fifo: three instances (8N1, 7E2, 8N1 with a 2-deep FIFO)
// driven by directed and random frames, checked against a frame-level model.
module tb_uart_echo_fifo;
    localparam int CA = 87;
    localparam int CB = 16;
    localparam int CC = 16;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int cycle = 0;
    always @(posedge clock) cycle++;

    logic       rstA = 1'b0, rstB = 1'b0, rstC = 1'b0;
    logic       rxA = 1'b1, rxB = 1'b1, rxC = 1'b1;
    logic       txA, txB, txC;
    logic [4:0] cntA, cntB;
    logic [1:0] cntC;
    logic       ovrA, parA, frmA, ovrB, parB, frmB, ovrC, parC, frmC;

    uart_echo_fifo dutA (
        .clock(clock), .reset(rstA), .uart_rx(rxA), .uart_tx(txA), .fifo_count(cntA),
        .rx_overrun(ovrA), .parity_err(parA), .frame_err(frmA)
    );

    uart_echo_fifo #(.CLKS_PER_BIT(CB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dutB (
        .clock(clock), .reset(rstB), .uart_rx(rxB), .uart_tx(txB), .fifo_count(cntB),
        .rx_overrun(ovrB), .parity_err(parB), .frame_err(frmB)
    );

    uart_echo_fifo #(.CLKS_PER_BIT(CC), .FIFO_DEPTH(2)) dutC (
        .clock(clock), .reset(rstC), .uart_rx(rxC), .uart_tx(txC), .fifo_count(cntC),
        .rx_overrun(ovrC), .parity_err(parC), .frame_err(frmC)
    );

    int checks = 0;
    int errors = 0;

    // Pulse counters count high cycles, so a stretched pulse shows up as an extra count
    int nOvr [3];
    int nPar [3];
    int nFrm [3];
    int txLow [3];
    int cntRise [3];
    int lastRise [3];
    logic [4:0] prevCnt [3];
    always @(negedge clock) begin
        nOvr[0] += int'(ovrA); nPar[0] += int'(parA); nFrm[0] += int'(frmA);
        nOvr[1] += int'(ovrB); nPar[1] += int'(parB); nFrm[1] += int'(frmB);
        nOvr[2] += int'(ovrC); nPar[2] += int'(parC); nFrm[2] += int'(frmC);
        txLow[0] += int'(!txA); txLow[1] += int'(!txB); txLow[2] += int'(!txC);
        if (cntA != 0 && prevCnt[0] == 0) begin cntRise[0]++; lastRise[0] = cycle; end
        if (cntB != 0 && prevCnt[1] == 0) begin cntRise[1]++; lastRise[1] = cycle; end
        if (cntC != 0 && prevCnt[2] == 0) begin cntRise[2]++; lastRise[2] = cycle; end
        prevCnt[0] = cntA;
        prevCnt[1] = cntB;
        prevCnt[2] = {3'b000, cntC};
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic txOf(input int s);
        case (s)
            0:       return txA;
            1:       return txB;
            default: return txC;
        endcase
    endfunction

    task automatic setRx(input int s, input logic v);
        case (s)
            0:       rxA = v;
            1:       rxB = v;
            default: rxC = v;
        endcase
    endtask

    // par: 0 none, 1 odd, 2 even; the returned bit makes the frame's parity valid
    function automatic bit parityOf(input int word, input int nBits, input int par);
        bit x;
        x = 1'b0;
        for (int i = 0; i < nBits; i++) x ^= word[i];
        return (par == 1) ? ~x : x;
    endfunction

    task automatic applyStimulus(input int s, input int word, input int nBits, input int par,
                                 input int stops, input int clks, input bit flipPar, input bit badStop);
        @(negedge clock);
        setRx(s, 1'b0);
        repeat (clks) @(negedge clock);
        for (int i = 0; i < nBits; i++) begin
            setRx(s, word[i]);
            repeat (clks) @(negedge clock);
        end
        if (par != 0) begin
            setRx(s, parityOf(word, nBits, par) ^ flipPar);
            repeat (clks) @(negedge clock);
        end
        for (int i = 0; i < stops; i++) begin
            setRx(s, !badStop);
            repeat (clks) @(negedge clock);
        end
        setRx(s, 1'b1);
    endtask

    task automatic captureFrame(input string tag, input int s, input int nBits, input int par,
                                input int stops, input int clks,
                                output int word, output int parBit, output int fallCycle);
        int t;
        int limit;
        word = 0; parBit = 0; fallCycle = -1; t = 0;
        limit = 40 * 12 * clks;
        while (txOf(s) !== 1'b0 && t < limit) begin
            @(negedge clock);
            t++;
        end
        checkOutput({tag, " start-timeout"}, int'(t >= limit), 0);
        if (t < limit) begin
            fallCycle = cycle;
            repeat (clks / 2) @(negedge clock);
            checkOutput({tag, " start-bit"}, int'(txOf(s)), 0);
            for (int i = 0; i < nBits; i++) begin
                repeat (clks) @(negedge clock);
                word |= int'(txOf(s)) << i;
            end
            if (par != 0) begin
                repeat (clks) @(negedge clock);
                parBit = int'(txOf(s));
            end
            for (int i = 0; i < stops; i++) begin
                repeat (clks) @(negedge clock);
                checkOutput({tag, " stop-bit"}, int'(txOf(s)), 1);
            end
        end
    endtask

    int w0, w1, p0, p1, f0, f1, rise0, t, snapA, snapB, snapC, snapD, goodCount, gi;
    int rw [5];
    int rg [5];
    int cw [5];
    int bw [4];
    int bb [4];
    int bexp [$];
    int ow [4];

    initial begin
        // Reset state with reset held low
        repeat (87) @(negedge clock);
        checkOutput("reset txA", int'(txA), 1);
        checkOutput("reset cntA", int'(cntA), 0);
        checkOutput("reset pulsesA", int'(ovrA) + int'(parA) + int'(frmA), 0);
        checkOutput("reset txB", int'(txB), 1);
        checkOutput("reset cntC", int'(cntC), 0);
        rstA = 1'b1; rstB = 1'b1; rstC = 1'b1;
        repeat (10) @(negedge clock);

        // 0x55 then 0x4B with a 4 bit-time gap
        fork
            begin
                applyStimulus(0, 'h55, 8, 0, 1, CA, 1'b0, 1'b0);
                repeat (4 * CA) @(negedge clock);
                applyStimulus(0, 'h4B, 8, 0, 1, CA, 1'b0, 1'b0);
            end
            begin
                captureFrame("echo1", 0, 8, 0, 1, CA, w0, p0, f0);
                rise0 = lastRise[0];
                captureFrame("echo2", 0, 8, 0, 1, CA, w1, p1, f1);
            end
        join
        checkOutput("echo1 data", w0, 'h55);
        checkOutput("echo2 data", w1, 'h4B);
        checkOutput("verdict-to-tx latency", f0 - rise0, 1);
        checkOutput("echo pulses", nOvr[0] + nPar[0] + nFrm[0], 0);

        // 7E2: good parity echoed, flipped parity dropped
        fork
            applyStimulus(1, 'h41, 7, 2, 2, CB, 1'b0, 1'b0);
            captureFrame("7E2 echo", 1, 7, 2, 2, CB, w0, p0, f0);
        join
        checkOutput("7E2 data", w0, 'h41);
        checkOutput("7E2 parity bit", p0, 0);
        repeat (2 * CB) @(negedge clock);
        snapA = txLow[1];
        applyStimulus(1, 'h41, 7, 2, 2, CB, 1'b1, 1'b0);
        repeat (30 * CB) @(negedge clock);
        checkOutput("7E2 parity_err count", nPar[1], 1);
        checkOutput("7E2 bad word not echoed", txLow[1] - snapA, 0);
        checkOutput("7E2 no frame_err", nFrm[1], 0);

        // Frame error on 0xA5, then a valid 0x3C
        repeat (4 * CA) @(negedge clock);
        fork
            begin
                applyStimulus(0, 'hA5, 8, 0, 1, CA, 1'b0, 1'b1);
                repeat (2 * CA) @(negedge clock);
                applyStimulus(0, 'h3C, 8, 0, 1, CA, 1'b0, 1'b0);
            end
            captureFrame("after frame_err", 0, 8, 0, 1, CA, w0, p0, f0);
        join
        checkOutput("frame_err echo data", w0, 'h3C);
        checkOutput("frame_err count", nFrm[0], 1);
        checkOutput("frame_err other pulses", nOvr[0] + nPar[0], 0);

        // Glitch of 20 cycles must be ignored
        repeat (4 * CA) @(negedge clock);
        snapA = txLow[0]; snapB = cntRise[0]; snapC = nOvr[0] + nPar[0] + nFrm[0];
        rxA = 1'b0;
        repeat (20) @(negedge clock);
        rxA = 1'b1;
        repeat (20 * CA) @(negedge clock);
        checkOutput("glitch tx activity", txLow[0] - snapA, 0);
        checkOutput("glitch fifo push", cntRise[0] - snapB, 0);
        checkOutput("glitch pulses", nOvr[0] + nPar[0] + nFrm[0] - snapC, 0);

        // Random 8N1 words with random gaps
        for (int i = 0; i < 5; i++) begin
            rw[i] = int'($urandom_range(0, 255));
            rg[i] = int'($urandom_range(0, 3));
        end
        fork
            for (int i = 0; i < 5; i++) begin
                applyStimulus(0, rw[i], 8, 0, 1, CA, 1'b0, 1'b0);
                repeat (rg[i] * CA) @(negedge clock);
            end
            for (int i = 0; i < 5; i++) begin
                captureFrame("rand8N1", 0, 8, 0, 1, CA, w0, p0, f0);
                cw[i] = w0;
            end
        join
        for (int i = 0; i < 5; i++) checkOutput($sformatf("rand8N1 word%0d", i), cw[i], rw[i]);
        checkOutput("rand8N1 fifo stays shallow", int'(cntA <= 1), 1);

        // Random 7E2 words, some with corrupted parity
        bexp.delete();
        snapA = nPar[1];
        for (int i = 0; i < 4; i++) begin
            bw[i] = int'($urandom_range(0, 127));
            bb[i] = (i == 0) ? 0 : int'($urandom_range(0, 1));
            if (bb[i] == 0) bexp.push_back(bw[i]);
        end
        goodCount = bexp.size();
        fork
            for (int i = 0; i < 4; i++) begin
                applyStimulus(1, bw[i], 7, 2, 2, CB, bb[i] != 0, 1'b0);
                repeat (CB) @(negedge clock);
            end
            for (int i = 0; i < goodCount; i++) begin
                captureFrame("rand7E2", 1, 7, 2, 2, CB, w0, p0, f0);
                checkOutput($sformatf("rand7E2 word%0d", i), w0, bexp[i]);
                checkOutput($sformatf("rand7E2 parity%0d", i), p0, int'(parityOf(bexp[i], 7, 2)));
            end
        join
        repeat (30 * CB) @(negedge clock);
        gi = 0;
        for (int i = 0; i < 4; i++) gi += bb[i];
        checkOutput("rand7E2 parity_err count", nPar[1] - snapA, gi);

        // Overrun with TX held off
        for (int i = 0; i < 4; i++) ow[i] = int'($urandom_range(0, 255));
        force dutC.txPop = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(2, ow[i], 8, 0, 1, CC, 1'b0, 1'b0);
        repeat (4) @(negedge clock);
        checkOutput("overrun fifo_count full", int'(cntC), 2);
        checkOutput("overrun pulse count", nOvr[2], 2);
        release dutC.txPop;
        captureFrame("overrun echo1", 2, 8, 0, 1, CC, w0, p0, f0);
        captureFrame("overrun echo2", 2, 8, 0, 1, CC, w1, p1, f1);
        checkOutput("overrun word0", w0, ow[0]);
        checkOutput("overrun word1", w1, ow[1]);
        checkOutput("back-to-back spacing", f1 - f0, 10 * CC);
        repeat (2 * CC) @(negedge clock);
        checkOutput("overrun drained", int'(cntC), 0);

        // Reset in the middle of TX data bit 3 of 0x55
        repeat (4 * CA) @(negedge clock);
        fork
            applyStimulus(0, 'h55, 8, 0, 1, CA, 1'b0, 1'b0);
            begin
                t = 0;
                while (txA !== 1'b0 && t < 20 * 12 * CA) begin
                    @(negedge clock);
                    t++;
                end
                checkOutput("reset-test tx start timeout", int'(t >= 20 * 12 * CA), 0);
                repeat (CA / 2 + 4 * CA) @(negedge clock);
            end
        join
        checkOutput("data bit3 before reset", int'(txA), 0);
        #2 rstA = 1'b0;
        #1;
        checkOutput("async reset tx", int'(txA), 1);
        checkOutput("async reset count", int'(cntA), 0);
        repeat (5) @(negedge clock);
        rstA = 1'b1;
        repeat (5) @(negedge clock);
        fork
            applyStimulus(0, 'h55, 8, 0, 1, CA, 1'b0, 1'b0);
            captureFrame("post-reset echo", 0, 8, 0, 1, CA, w0, p0, f0);
        join
        checkOutput("post-reset data", w0, 'h55);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
